esc_cmd_rx: RTL

Serial command receiver that sources the 8-bit throttle command for the `esc` pulse generator, replacing the demo sawtooth. It receives framed bytes from the AVR serial line (`avr_tx`), validates each frame, and holds the last good command. A watchdog forces a zero (motor-off) command when valid frames stop arriving.

---
 rtl/esc_cmd_pkg.sv | 31 +++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/esc_cmd_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/esc_cmd_pkg.sv
// Shared constants and types for the ESC serial command receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package esc_cmd_pkg;

  // Frame header byte
  localparam logic [7:0] HDR = 8'hA5;

  // Frame parser states
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GOT_HDR = 2'd1,
    GOT_VAL = 2'd2
  } parse_st_t;

  // Byte receiver states
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_DONE  = 3'd4
  } rx_st_t;

  // Bit period in system clocks; callers must choose an exact integer ratio
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
// Latency: strobe one clock after the stop-bit midpoint sample (+2 clocks synchroniser).
// Backpressure: none; strobes are single-cycle and data is valid only with byte_stb.
// Ports: clk, rst (async active-high), rx (async serial in, idle high),
//        data[7:0] received byte, byte_stb good byte pulse, ferr_stb bad-stop pulse.
module uart_rx_byte
  import esc_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_stb,
  output logic       ferr_stb
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  rx_st_t        r_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_stop;
  logic          r_byte_stb;
  logic          r_ferr_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchroniser resets to idle-high so release never looks like a start edge
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prev     <= 1'b1;
      r_st       <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop     <= 1'b0;
      r_byte_stb <= 1'b0;
      r_ferr_stb <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_byte_stb <= 1'b0;
      r_ferr_stb <= 1'b0;
      case (r_st)
        RX_IDLE: begin
          // The detect cycle itself counts as the first clock of the start bit
          if (r_prev && !r_sync2) begin
            r_st  <= RX_START;
            r_cnt <= CW'(1);
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_st <= RX_IDLE;  // line back high at mid-start: glitch
            end else begin
              r_st      <= RX_DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};  // LSB first
            if (r_bit_idx == 3'd7) r_st <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt  <= '0;
            r_stop <= r_sync2;
            r_st   <= RX_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DONE: begin
          r_byte_stb <= r_stop;
          r_ferr_stb <= ~r_stop;
          r_st       <= RX_IDLE;
        end
        default: r_st <= RX_IDLE;
      endcase
    end
  end

  assign data     = r_shift;
  assign byte_stb = r_byte_stb;
  assign ferr_stb = r_ferr_stb;

endmodule

// File: rtl/esc_cmd_rx.sv
// Serial throttle command receiver: parses A5/V/~V frames, holds last good command, watchdog failsafe.
// Latency: cmd/cmd_stb/failsafe update 2 clocks after the check-byte stop midpoint (+2 synchroniser).
// Backpressure: none; outputs are registered pulses/levels, bytes are never held.
// Ports: clk, rst (async active-high), rx (serial in), cmd[7:0] throttle,
//        cmd_stb load pulse, frame_err reject pulse, failsafe watchdog-expired level.
module esc_cmd_rx
  import esc_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 500_000,
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter int unsigned GAP_BITS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       cmd_stb,
  output logic       frame_err,
  output logic       failsafe
);

  localparam int unsigned CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned GAP_CYC = GAP_BITS * CPB;
  localparam int unsigned GW      = $clog2(GAP_CYC);
  localparam int unsigned WW      = $clog2(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP_CYC - 1);
  localparam logic [WW-1:0] WD_M1  = WW'(TIMEOUT_CYC - 1);

  logic [7:0] w_data;
  logic       w_byte_stb;
  logic       w_ferr_stb;
  logic       w_valid;

  parse_st_t  r_st;
  logic [7:0] r_val;
  logic [GW-1:0] r_gap_cnt;
  logic [WW-1:0] r_wd_cnt;
  logic [7:0] r_cmd;
  logic       r_cmd_stb;
  logic       r_frame_err;
  logic       r_failsafe;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .data    (w_data),
    .byte_stb(w_byte_stb),
    .ferr_stb(w_ferr_stb)
  );

  // Check byte completes a good frame
  assign w_valid = w_byte_stb && (r_st == GOT_VAL) && (w_data == ~r_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= HUNT;
      r_val       <= '0;
      r_gap_cnt   <= '0;
      r_wd_cnt    <= '0;
      r_cmd       <= '0;
      r_cmd_stb   <= 1'b0;
      r_frame_err <= 1'b0;
      r_failsafe  <= 1'b1;  // motor off until the first good frame
    end else begin
      r_cmd_stb   <= 1'b0;
      r_frame_err <= 1'b0;

      // Parser; an arriving byte takes priority over a coincident gap timeout
      if (w_ferr_stb) begin
        r_frame_err <= 1'b1;
        r_st        <= HUNT;
        r_gap_cnt   <= '0;
      end else if (w_byte_stb) begin
        r_gap_cnt <= '0;
        case (r_st)
          HUNT: begin
            if (w_data == HDR) r_st <= GOT_HDR;
          end
          GOT_HDR: begin
            r_val <= w_data;
            r_st  <= GOT_VAL;
          end
          GOT_VAL: begin
            r_st <= HUNT;
            if (w_valid) r_cmd_stb   <= 1'b1;
            else         r_frame_err <= 1'b1;
          end
          default: r_st <= HUNT;
        endcase
      end else if (r_st != HUNT) begin
        if (r_gap_cnt == GAP_M1) begin
          r_frame_err <= 1'b1;
          r_st        <= HUNT;
          r_gap_cnt   <= '0;
        end else begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
        end
      end

      // Watchdog; a good frame on the expiry edge wins, counter saturates otherwise
      if (w_valid) begin
        r_wd_cnt   <= '0;
        r_failsafe <= 1'b0;
        r_cmd      <= r_val;
      end else if (r_wd_cnt == WD_M1) begin
        r_failsafe <= 1'b1;
        r_cmd      <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_stb   = r_cmd_stb;
  assign frame_err = r_frame_err;
  assign failsafe  = r_failsafe;

endmodule
